// File: rtl/breadboard_sweep_ctrl.sv
// breadboard_sweep_ctrl: walks the Breadboard inputs through codes 0..15,
// waits SETTLE_CYCLES clocks per code, captures the ten outputs and streams
// each row out while folding it into a rotate-xor signature.
//
// Row stream handshake: row_valid rises with row_idx/row_data already stable
// and all three hold until a clock edge sees row_valid & row_ready; that edge
// is the transfer, and row_valid drops on it.
module breadboard_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] wxyz,
    input  logic [9:0] f_in,
    output logic       row_valid,
    input  logic       row_ready,
    output logic [3:0] row_idx,
    output logic [9:0] row_data,
    output logic [9:0] signature,
    output logic       busy,
    output logic       done,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] wxyz_d;
    logic       valid_d;
    logic [3:0] idx_d;
    logic [9:0] data_d;
    logic [9:0] sig_d;
    logic       busy_d;
    logic       done_d;

    assign state_dbg = state_q;

    // Next-state and next-output logic; every output is a register fed from here.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wxyz_d  = wxyz;
        valid_d = row_valid;
        idx_d   = row_idx;
        data_d  = row_data;
        sig_d   = signature;
        done_d  = 1'b0;

        if (state_q != IDLE && abort) begin
            // Abort beats a same-cycle handshake: the pending row is dropped unfolded.
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = SETTLE;
                        wxyz_d  = 4'd0;
                        idx_d   = 4'd0;
                        sig_d   = 10'd0;
                        cnt_d   = SETTLE_INIT;
                    end
                end
                SETTLE: begin
                    if (cnt_q == 4'd0) begin
                        data_d  = f_in;
                        valid_d = 1'b1;
                        state_d = OUT;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                OUT: begin
                    if (row_ready) begin
                        valid_d = 1'b0;
                        sig_d   = {signature[8:0], signature[9]} ^ row_data;
                        if (row_idx == 4'd15) begin
                            state_d = DONE;
                        end else begin
                            wxyz_d  = wxyz + 4'd1;
                            idx_d   = row_idx + 4'd1;
                            cnt_d   = SETTLE_INIT;
                            state_d = SETTLE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            wxyz      <= 4'd0;
            row_valid <= 1'b0;
            row_idx   <= 4'd0;
            row_data  <= 10'd0;
            signature <= 10'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wxyz      <= wxyz_d;
            row_valid <= valid_d;
            row_idx   <= idx_d;
            row_data  <= data_d;
            signature <= sig_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_breadboard_sweep_ctrl.sv
// Bench for breadboard_sweep_ctrl: two instances (SETTLE_CYCLES 3 and 1) driven
// by a table-based Breadboard, checked row by row against a sweep model.
module tb_breadboard_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic start, abort, row_ready;
    bit   sel;

    logic [9:0] tbl [16];

    logic [3:0] a_wxyz, b_wxyz, a_idx, b_idx;
    logic [9:0] a_f, b_f, a_data, b_data, a_sig, b_sig;
    logic       a_valid, b_valid, a_busy, b_busy, a_done, b_done;
    logic [1:0] a_state, b_state;

    logic [3:0] obs_wxyz, obs_idx;
    logic [9:0] obs_data, obs_sig;
    logic       obs_valid, obs_busy, obs_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Breadboard stand-in: combinational lookup of the current truth table.
    assign a_f = tbl[a_wxyz];
    assign b_f = tbl[b_wxyz];

    assign obs_wxyz  = sel ? b_wxyz  : a_wxyz;
    assign obs_idx   = sel ? b_idx   : a_idx;
    assign obs_data  = sel ? b_data  : a_data;
    assign obs_sig   = sel ? b_sig   : a_sig;
    assign obs_valid = sel ? b_valid : a_valid;
    assign obs_busy  = sel ? b_busy  : a_busy;
    assign obs_done  = sel ? b_done  : a_done;

    breadboard_sweep_ctrl #(.SETTLE_CYCLES(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .abort(abort & ~sel),
        .wxyz(a_wxyz), .f_in(a_f), .row_valid(a_valid), .row_ready(row_ready),
        .row_idx(a_idx), .row_data(a_data), .signature(a_sig), .busy(a_busy),
        .done(a_done), .state_dbg(a_state)
    );

    breadboard_sweep_ctrl #(.SETTLE_CYCLES(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .abort(abort & sel),
        .wxyz(b_wxyz), .f_in(b_f), .row_valid(b_valid), .row_ready(row_ready),
        .row_idx(b_idx), .row_data(b_data), .signature(b_sig), .busy(b_busy),
        .done(b_done), .state_dbg(b_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wxyz"},  obs_wxyz,  0);
        check({tag, "_valid"}, obs_valid, 0);
        check({tag, "_idx"},   obs_idx,   0);
        check({tag, "_data"},  obs_data,  0);
        check({tag, "_sig"},   obs_sig,   0);
        check({tag, "_busy"},  obs_busy,  0);
        check({tag, "_done"},  obs_done,  0);
    endtask

    // One sweep on the selected instance. Negative row numbers disable a feature.
    task automatic sweep(input bit use_b, input int stall_row, input int abort_row,
                         input int mstart_row, input int rst_row,
                         input bit rand_ready, input bit chk_time);
        int         cyc, idx, settle, stall_left;
        logic [9:0] msig;
        bit         fin;
        sel    = use_b;
        settle = use_b ? 1 : 3;
        for (int i = 1; i < 15; i++) tbl[i] = 10'($urandom);
        @(negedge clk);
        start = 1'b1; row_ready = 1'b1; abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; idx = 0; msig = 10'd0; stall_left = 10; fin = 1'b0;
        check("busy_after_start", obs_busy, 1);
        check("wxyz_after_start", obs_wxyz, 0);
        while (!fin) begin
            if (cyc > 600) begin
                check("sweep_timeout", cyc, 0);
                fin = 1'b1;
            end else if (obs_valid) begin
                check("row_idx", obs_idx, idx);
                check("row_data", obs_data, tbl[idx]);
                check("wxyz_hold", obs_wxyz, idx);
                check("busy_row", obs_busy, 1);
                if (chk_time) check("row_time", cyc, (settle + 1) * idx + settle);
                if (idx == rst_row) begin
                    rst_n = 1'b0;
                    #1;
                    check_all_zero("midrst");
                    @(negedge clk);
                    rst_n = 1'b1;
                    repeat (3) begin
                        @(negedge clk);
                        check("no_resume_busy", obs_busy, 0);
                        check("no_resume_valid", obs_valid, 0);
                    end
                    fin = 1'b1;
                end else if (idx == abort_row) begin
                    abort = 1'b1; row_ready = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    check("abort_busy", obs_busy, 0);
                    check("abort_valid", obs_valid, 0);
                    check("abort_sig", obs_sig, msig);
                    check("abort_wxyz", obs_wxyz, idx);
                    repeat (3) begin
                        @(negedge clk);
                        check("abort_no_done", obs_done, 0);
                        check("abort_idle", obs_busy, 0);
                    end
                    fin = 1'b1;
                end else if (idx == stall_row && stall_left > 0) begin
                    row_ready = 1'b0;
                    stall_left--;
                    @(negedge clk);
                    cyc++;
                    check("stall_valid", obs_valid, 1);
                end else begin
                    row_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                    if (row_ready) msig = {msig[8:0], msig[9]} ^ tbl[idx];
                    @(negedge clk);
                    cyc++;
                    if (row_ready) begin
                        if (idx == 15) begin
                            check("done_not_early", obs_done, 0);
                            check("busy_in_done", obs_busy, 1);
                            @(negedge clk);
                            cyc++;
                            check("done_pulse", obs_done, 1);
                            check("done_busy", obs_busy, 0);
                            check("final_sig", obs_sig, msig);
                            check("final_wxyz", obs_wxyz, 15);
                            check("final_valid", obs_valid, 0);
                            if (chk_time) check("done_time", cyc, 16 * (settle + 1) + 1);
                            @(negedge clk);
                            check("done_one_cycle", obs_done, 0);
                            fin = 1'b1;
                        end
                        idx++;
                    end
                end
            end else begin
                row_ready = 1'($urandom_range(0, 1));
                start = (idx == mstart_row);
                check("no_done_mid", obs_done, 0);
                @(negedge clk);
                cyc++;
                start = 1'b0;
            end
        end
        row_ready = 1'b1;
    endtask

    initial begin
        tbl[0]  = 10'h194;
        tbl[15] = 10'h266;
        for (int i = 1; i < 15; i++) tbl[i] = 10'($urandom);
        sel = 1'b0; start = 1'b0; abort = 1'b0; row_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_a");
        sel = 1'b1;
        #1;
        check_all_zero("reset_b");
        sel = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        sweep(1'b0, -1, -1, -1, -1, 1'b0, 1'b1);  // timing, fixed rows 0/15, model fold
        sweep(1'b0,  5, -1, -1, -1, 1'b0, 1'b0);  // 10-clock stall on row 5
        sweep(1'b0, -1,  7, -1, -1, 1'b0, 1'b0);  // abort on row 7 with ready high
        sweep(1'b0, -1, -1,  3,  9, 1'b0, 1'b0);  // stray start, then reset at row 9
        sweep(1'b0, -1, -1, -1, -1, 1'b0, 1'b1);  // fresh sweep after reset
        sweep(1'b1, -1, -1, -1, -1, 1'b0, 1'b1);  // SETTLE_CYCLES=1 timing
        for (int k = 0; k < 4; k++) begin
            sweep(k[0], -1, -1, int'($urandom_range(0, 15)), -1, 1'b1, 1'b0);
        end
        sweep(1'b1, -1, int'($urandom_range(1, 14)), -1, -1, 1'b1, 1'b0);
        sweep(1'b1, -1, -1, -1, -1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
